// File: rtl/audio_pkg.sv
// Shared audio-path types and default geometry for the I2S transmitter.
// The transmitter's optional left-justified mode is enabled with I2S_TX_LJ_MODE_EN.
package audio_pkg;

  typedef enum logic {
    FMT_I2S = 1'b0,
    FMT_LJ  = 1'b1
  } fmt_e;

  localparam int DEF_SAMPLE_W = 24;
  localparam int DEF_SLOT_W   = 32;
  localparam int DEF_BCK_HALF = 4;

endpackage

// File: rtl/i2s_tx_clkgen.sv
// Bit/word clock generator: divides clk into BCK, counts bit slots and drives LRCK.
// Emits single-clk strobes on every BCK falling edge and at frame / right-slot starts.
module i2s_tx_clkgen
  import audio_pkg::*;
#(
  parameter int SLOT_W   = DEF_SLOT_W,
  parameter int BCK_HALF = DEF_BCK_HALF
) (
  input  logic clk,
  input  logic rst,
  output logic bck,
  output logic lrck,
  output logic fe,
  output logic frame_start,
  output logic right_start
);

  localparam int DIV_W = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_W);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(BCK_HALF - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(2 * SLOT_W - 1);
  localparam logic [BIT_W-1:0] RIGHT_PREV = BIT_W'(SLOT_W - 1);
  localparam logic [BIT_W-1:0] RIGHT_FIRST = BIT_W'(SLOT_W);

  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [BIT_W-1:0] bit_cnt_nxt;
  logic             div_wrap;

  assign div_wrap    = (div_cnt == DIV_LAST);
  assign fe          = div_wrap && bck;
  assign bit_cnt_nxt = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
  // Strobes decode the pre-edge count so they line up with the edge that wraps it.
  assign frame_start = fe && (bit_cnt == BIT_LAST);
  assign right_start = fe && (bit_cnt == RIGHT_PREV);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      bck     <= 1'b0;
      bit_cnt <= BIT_LAST;
      lrck    <= 1'b0;
    end else begin
      div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
      if (div_wrap) bck <= ~bck;
      if (fe) begin
        bit_cnt <= bit_cnt_nxt;
        lrck    <= (bit_cnt_nxt >= RIGHT_FIRST);
      end
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// I2S / left-justified stereo transmitter with one-frame holding buffer, mute and underrun flag.
// Define I2S_TX_LJ_MODE_EN to add the lj_mode port; otherwise the format is fixed to I2S.
module i2s_tx
  import audio_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int SLOT_W   = DEF_SLOT_W,
  parameter int BCK_HALF = DEF_BCK_HALF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_valid,
  output logic                       sample_ready,
  input  logic signed [SAMPLE_W-1:0] left_data,
  input  logic signed [SAMPLE_W-1:0] right_data,
  input  logic                       mute,
  output logic                       underrun,
`ifdef I2S_TX_LJ_MODE_EN
  input  logic                       lj_mode,
`endif
  output logic                       i2s_lrck,
  output logic                       i2s_bck,
  output logic                       i2s_data
);

  localparam int SR_W = SLOT_W + 1;

  logic                       fe;
  logic                       frame_start;
  logic                       right_start;
  logic                       accept;
  logic                       buf_full;
  logic signed [SAMPLE_W-1:0] buf_l;
  logic signed [SAMPLE_W-1:0] buf_r;
  logic signed [SAMPLE_W-1:0] right_hold;
  logic [SR_W-1:0]            sr;
  fmt_e                       fmt_in;
  fmt_e                       fmt_q;

  // I2S leaves a leading zero so the MSB lands one BCK after the LRCK edge; LJ does not.
  function automatic logic [SR_W-1:0] load_word(input fmt_e fmt,
                                                input logic signed [SAMPLE_W-1:0] smp);
    logic [SR_W-1:0] w;
    w = '0;
    w[SAMPLE_W-1:0] = smp;
    if (fmt == FMT_LJ) return w << (SR_W - SAMPLE_W);
    return w << (SLOT_W - SAMPLE_W);
  endfunction

`ifdef I2S_TX_LJ_MODE_EN
  assign fmt_in = lj_mode ? FMT_LJ : FMT_I2S;
`else
  assign fmt_in = FMT_I2S;
`endif

  i2s_tx_clkgen #(
    .SLOT_W  (SLOT_W),
    .BCK_HALF(BCK_HALF)
  ) u_clkgen (
    .clk        (clk),
    .rst        (rst),
    .bck        (i2s_bck),
    .lrck       (i2s_lrck),
    .fe         (fe),
    .frame_start(frame_start),
    .right_start(right_start)
  );

  assign sample_ready = ~buf_full;
  assign accept       = sample_valid && sample_ready;
  assign i2s_data     = sr[SR_W-1];

  // A frame start in the accept clk sees the buffer as empty; the new pair waits a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_full <= 1'b0;
      underrun <= 1'b0;
      fmt_q    <= FMT_I2S;
      sr       <= '0;
    end else begin
      underrun <= frame_start && !buf_full;
      if (frame_start) begin
        buf_full <= 1'b0;
        fmt_q    <= fmt_in;
      end
      if (accept) buf_full <= 1'b1;

      if (frame_start)      sr <= (buf_full && !mute) ? load_word(fmt_in, buf_l) : '0;
      else if (right_start) sr <= load_word(fmt_q, right_hold);
      else if (fe)          sr <= {sr[SR_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      buf_l <= left_data;
      buf_r <= right_data;
    end
    if (frame_start) right_hold <= (buf_full && !mute) ? buf_r : '0;
  end

endmodule
